// File: rtl/matrix_flush_sequencer.sv
// rtl/matrix_flush_sequencer.sv - frame pass-through with end-of-frame flush lines for the 3x3 matrix generator (optional LINE_LEN_CHECK_EN)
module matrix_flush_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int FLUSH_LINES = 2,
    parameter int HBLANK      = 16,
    parameter int FLUSH_VALUE = 0,
    parameter int CNT_W       = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vsync,
    input  logic                  in_href,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vsync,
    output logic                  out_href,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      pix_cnt,
    output logic [CNT_W-1:0]      line_cnt,
    output logic                  flush_active,
    output logic                  frame_done,
    output logic                  frame_drop
`ifdef LINE_LEN_CHECK_EN
    ,
    output logic                  line_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        FLUSH_LINE,
        FLUSH_BLANK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0]      CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]      HDISP_LAST  = CNT_W'(IMG_HDISP - 1);
    localparam logic [CNT_W-1:0]      VDISP_LAST  = CNT_W'(IMG_VDISP - 1);
    localparam logic [CNT_W-1:0]      HBLANK_LAST = CNT_W'(HBLANK - 1);
    localparam logic [1:0]            FLUSH_NUM   = 2'(FLUSH_LINES);
    localparam logic [DATA_WIDTH-1:0] FLUSH_PIX   = DATA_WIDTH'(FLUSH_VALUE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t                state, state_nxt;
    logic                  vs_prev;
    logic                  href_seen, href_seen_nxt;
    logic [CNT_W-1:0]      in_lines, in_lines_nxt;
    logic [CNT_W-1:0]      blank_cnt, blank_cnt_nxt;
    logic [1:0]            flush_cnt, flush_cnt_nxt;
    logic                  out_vsync_nxt, out_href_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [CNT_W-1:0]      pix_cnt_nxt, line_cnt_nxt;
    logic                  flush_active_nxt, frame_done_nxt, frame_drop_nxt;
`ifdef LINE_LEN_CHECK_EN
    logic                  line_err_nxt;
`endif

    logic vs_rise;
    logic in_href_fall;

    // vs_prev resets high so a frame already in progress at reset release is never taken as a new one
    assign vs_rise      = in_vsync & ~vs_prev;
    // out_href holds last cycle's in_href while passing through
    assign in_href_fall = out_href & ~in_href;

    // State, counters and every output are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vs_prev      <= 1'b1;
            href_seen    <= 1'b0;
            in_lines     <= '0;
            blank_cnt    <= '0;
            flush_cnt    <= '0;
            out_vsync    <= 1'b0;
            out_href     <= 1'b0;
            out_data     <= '0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            flush_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_drop   <= 1'b0;
`ifdef LINE_LEN_CHECK_EN
            line_err     <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            vs_prev      <= in_vsync;
            href_seen    <= href_seen_nxt;
            in_lines     <= in_lines_nxt;
            blank_cnt    <= blank_cnt_nxt;
            flush_cnt    <= flush_cnt_nxt;
            out_vsync    <= out_vsync_nxt;
            out_href     <= out_href_nxt;
            out_data     <= out_data_nxt;
            pix_cnt      <= pix_cnt_nxt;
            line_cnt     <= line_cnt_nxt;
            flush_active <= flush_active_nxt;
            frame_done   <= frame_done_nxt;
            frame_drop   <= frame_drop_nxt;
`ifdef LINE_LEN_CHECK_EN
            line_err     <= line_err_nxt;
`endif
        end
    end

    // Next state, next output values and position counters
    always_comb begin
        state_nxt        = state;
        href_seen_nxt    = href_seen;
        in_lines_nxt     = in_lines;
        blank_cnt_nxt    = blank_cnt;
        flush_cnt_nxt    = flush_cnt;
        out_vsync_nxt    = 1'b0;
        out_href_nxt     = 1'b0;
        out_data_nxt     = '0;
        pix_cnt_nxt      = '0;
        line_cnt_nxt     = line_cnt;
        flush_active_nxt = 1'b0;
        frame_done_nxt   = 1'b0;
        frame_drop_nxt   = 1'b0;
`ifdef LINE_LEN_CHECK_EN
        line_err_nxt     = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt     = PASS;
                    out_vsync_nxt = 1'b1;
                    out_href_nxt  = in_href;
                    out_data_nxt  = in_data;
                end
            end
            PASS: begin
`ifdef LINE_LEN_CHECK_EN
                if (in_href_fall && (pix_cnt != HDISP_LAST))
                    line_err_nxt = 1'b1;
`endif
                if (in_href_fall && (in_lines == VDISP_LAST)) begin
                    // last image line done: the block now owns out_vsync
                    state_nxt        = FLUSH_BLANK;
                    out_vsync_nxt    = 1'b1;
                    flush_active_nxt = 1'b1;
                    blank_cnt_nxt    = '0;
                    flush_cnt_nxt    = '0;
                end else if (!in_vsync) begin
                    // short frame: nothing is flushed
                    state_nxt      = DONE;
                    frame_done_nxt = 1'b1;
                end else begin
                    out_vsync_nxt = 1'b1;
                    out_href_nxt  = in_href;
                    out_data_nxt  = in_data;
                    if (in_href_fall)
                        in_lines_nxt = sat_inc(in_lines);
                end
            end
            FLUSH_BLANK: begin
                frame_drop_nxt = vs_rise;
                out_vsync_nxt  = 1'b1;
                if (flush_cnt == FLUSH_NUM) begin
                    state_nxt      = DONE;
                    out_vsync_nxt  = 1'b0;
                    frame_done_nxt = 1'b1;
                end else if (blank_cnt == HBLANK_LAST) begin
                    state_nxt        = FLUSH_LINE;
                    out_href_nxt     = 1'b1;
                    out_data_nxt     = FLUSH_PIX;
                    flush_active_nxt = 1'b1;
                    blank_cnt_nxt    = '0;
                end else begin
                    flush_active_nxt = 1'b1;
                    blank_cnt_nxt    = blank_cnt + CNT_ONE;
                end
            end
            FLUSH_LINE: begin
                frame_drop_nxt = vs_rise;
                out_vsync_nxt  = 1'b1;
                if (pix_cnt == HDISP_LAST) begin
                    state_nxt        = FLUSH_BLANK;
                    flush_cnt_nxt    = flush_cnt + 2'd1;
                    flush_active_nxt = ((flush_cnt + 2'd1) != FLUSH_NUM);
                end else begin
                    out_href_nxt     = 1'b1;
                    out_data_nxt     = FLUSH_PIX;
                    flush_active_nxt = 1'b1;
                end
            end
            DONE: begin
                frame_drop_nxt = vs_rise;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // line_cnt names the line on out_href, so it advances when the next line starts
        if (out_href_nxt) begin
            if (out_href)
                pix_cnt_nxt = sat_inc(pix_cnt);
            else if (href_seen)
                line_cnt_nxt = sat_inc(line_cnt);
            href_seen_nxt = 1'b1;
        end

        if ((state_nxt == IDLE) || (state_nxt == DONE)) begin
            href_seen_nxt = 1'b0;
            in_lines_nxt  = '0;
            blank_cnt_nxt = '0;
            flush_cnt_nxt = '0;
            pix_cnt_nxt   = '0;
            line_cnt_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_matrix_flush_sequencer.sv
// tb/tb_matrix_flush_sequencer.sv - scoreboard bench for matrix_flush_sequencer
module tb_matrix_flush_sequencer;

    localparam int DW     = 8;
    localparam int HD     = 8;
    localparam int VD     = 4;
    localparam int FL     = 2;
    localparam int HB     = 3;
    localparam int FV     = 0;
    localparam int CW     = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vsync, in_href;
    logic [DW-1:0] in_data;
    logic          out_vsync, out_href;
    logic [DW-1:0] out_data;
    logic [CW-1:0] pix_cnt, line_cnt;
    logic          flush_active, frame_done, frame_drop;
`ifdef LINE_LEN_CHECK_EN
    logic          line_err;
`endif

    matrix_flush_sequencer #(
        .DATA_WIDTH(DW), .IMG_HDISP(HD), .IMG_VDISP(VD), .FLUSH_LINES(FL),
        .HBLANK(HB), .FLUSH_VALUE(FV), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vsync(in_vsync), .in_href(in_href), .in_data(in_data),
        .out_vsync(out_vsync), .out_href(out_href), .out_data(out_data),
        .pix_cnt(pix_cnt), .line_cnt(line_cnt),
        .flush_active(flush_active), .frame_done(frame_done), .frame_drop(frame_drop)
`ifdef LINE_LEN_CHECK_EN
        , .line_err(line_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            pix;
        int            line;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    int err_cnt  = 0;
    int line_max = 0;
    int last_line_max = 0;
    int flush_seen = 0;
    int last_flush_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard for every out_href pixel and gathers per-frame statistics
    always @(negedge clk) begin
        if (!rst_n) begin
            line_max   = 0;
            flush_seen = 0;
        end else begin
            if (out_href) begin
                check("href_in_frame", out_vsync, 1);
                if (sb.size() == 0) begin
                    check("unexpected_px", out_href, 0);
                end else begin
                    e = sb.pop_front();
                    check("px_data", out_data, e.data);
                    check("px_pix_cnt", pix_cnt, e.pix);
                    check("px_line_cnt", line_cnt, e.line);
                    check("px_cycle", cyc, e.cyc);
                end
            end
            if (frame_drop) drop_cnt++;
`ifdef LINE_LEN_CHECK_EN
            if (line_err) err_cnt++;
`endif
            if (frame_done) begin
                done_cnt++;
                check("done_vsync_low", out_vsync, 0);
                check("done_flush_low", flush_active, 0);
                last_line_max   = line_max;
                last_flush_seen = flush_seen;
                line_max        = 0;
                flush_seen      = 0;
            end else if (out_vsync) begin
                if (int'(line_cnt) > line_max) line_max = int'(line_cnt);
                if (flush_active) flush_seen = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int l, input int n, input bit accept, input bit rnd,
                              output int last_cyc);
        logic [DW-1:0] d;
        for (int p = 0; p < n; p++) begin
            d = rnd ? DW'($urandom_range(0, 255)) : DW'(l * HD + p + 1);
            in_href = 1'b1;
            in_data = d;
            if (accept) sb.push_back('{d, p, l, cyc + 1});
            last_cyc = cyc + 1;
            step();
        end
        in_href = 1'b0;
        in_data = '0;
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input bit accept,
                               input bit flush, input int vs_tail, input bit rnd);
        int last;
        last = 0;
        in_vsync = 1'b1;
        step();
        step();
        for (int l = 0; l < nlines; l++) begin
            drive_line(l, (l == short_line) ? HD - 1 : HD, accept, rnd, last);
            if (flush && l == nlines - 1) begin
                for (int j = 0; j < FL; j++)
                    for (int p = 0; p < HD; p++)
                        sb.push_back('{DW'(FV), p, VD + j, last + (j + 1) * HB + j * HD + p + 1});
            end
            step();
            step();
        end
        repeat (vs_tail) step();
        in_vsync = 1'b0;
        step();
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int i = 0; i < budget && done_cnt == start; i++) step();
        if (done_cnt == start) check("done_timeout", done_cnt, start + 1);
    endtask

    int d0, r0, x0, lc;

    initial begin
        rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vsync", out_vsync, 0);
        check("rst_href", out_href, 0);
        check("rst_data", out_data, 0);
        check("rst_pix", pix_cnt, 0);
        check("rst_line", line_cnt, 0);
        check("rst_flush", flush_active, 0);
        check("rst_done", frame_done, 0);
        check("rst_drop", frame_drop, 0);
        rst_n = 1'b1;
        step(); step();

        // normal frame, data 1..32, then two flush lines
        d0 = done_cnt; r0 = drop_cnt;
        drive_frame(VD, -1, 1, 1, 2, 0);
        wait_done(d0, 200);
        check("normal_done", done_cnt - d0, 1);
        check("normal_drop", drop_cnt - r0, 0);
        check("normal_line_max", last_line_max, VD + FL - 1);
        check("normal_flush_seen", last_flush_seen, 1);
        check("normal_sb_empty", sb.size(), 0);

        // back-to-back frame starting two clocks after frame_done, random data
        d0 = done_cnt; r0 = drop_cnt;
        drive_frame(VD, -1, 1, 1, 2, 1);
        wait_done(d0, 200);
        check("b2b_done", done_cnt - d0, 1);
        check("b2b_drop", drop_cnt - r0, 0);
        check("b2b_sb_empty", sb.size(), 0);
        repeat (3) step();

        // early vsync drop after two lines
        d0 = done_cnt;
        drive_frame(2, -1, 1, 0, 3, 0);
        wait_done(d0, 50);
        check("early_done", done_cnt - d0, 1);
        check("early_line_max", last_line_max, 1);
        check("early_flush_seen", last_flush_seen, 0);
        check("early_sb_empty", sb.size(), 0);
        repeat (3) step();

        // a new frame arriving during the flush is dropped whole
        d0 = done_cnt; r0 = drop_cnt;
        drive_frame(VD, -1, 1, 1, 0, 0);
        for (int i = 0; i < 50 && !flush_active; i++) step();
        check("flush_wait", flush_active, 1);
        drive_frame(VD, -1, 0, 0, 2, 0);
        repeat (3) step();
        check("drop_done", done_cnt - d0, 1);
        check("drop_pulse", drop_cnt - r0, 1);
        check("drop_sb_empty", sb.size(), 0);
        d0 = done_cnt; r0 = drop_cnt;
        drive_frame(VD, -1, 1, 1, 2, 1);
        wait_done(d0, 200);
        check("after_drop_done", done_cnt - d0, 1);
        check("after_drop_nodrop", drop_cnt - r0, 0);
        repeat (3) step();

        // reset in the middle of line 2
        in_vsync = 1'b1;
        step(); step();
        drive_line(0, HD, 1, 0, lc); step(); step();
        drive_line(1, HD, 1, 0, lc); step(); step();
        for (int p = 0; p < 3; p++) begin
            in_href = 1'b1;
            in_data = DW'(2 * HD + p + 1);
            sb.push_back('{DW'(2 * HD + p + 1), p, 2, cyc + 1});
            step();
        end
        #5;
        in_data = DW'(2 * HD + 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vsync", out_vsync, 0);
        check("mid_rst_href", out_href, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_pix", pix_cnt, 0);
        check("mid_rst_line", line_cnt, 0);
        check("mid_rst_flush", flush_active, 0);
        check("mid_rst_sb_empty", sb.size(), 0);
        step(); step();
        rst_n = 1'b1;
        in_href = 1'b0;
        step();
        d0 = done_cnt;
        drive_line(2, HD, 0, 0, lc); step(); step();
        drive_line(3, HD, 0, 0, lc); step(); step();
        in_vsync = 1'b0;
        repeat (3) step();
        check("post_rst_no_done", done_cnt - d0, 0);
        drive_frame(VD, -1, 1, 1, 2, 1);
        wait_done(d0, 200);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_sb_empty", sb.size(), 0);
        repeat (3) step();

`ifdef LINE_LEN_CHECK_EN
        // line 1 is one pixel short
        d0 = done_cnt; x0 = err_cnt;
        drive_frame(VD, 1, 1, 1, 2, 0);
        wait_done(d0, 200);
        check("len_err_pulse", err_cnt - x0, 1);
        check("len_flush_seen", last_flush_seen, 1);
        check("len_sb_empty", sb.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
